fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the decode/control logic.
- Owns the fetch PC and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instruction words, with their PCs, in a small FIFO and hands them to decode over a valid/ready handshake.
- Redirects the fetch PC on npc_op results from the control unit (branch/jal/jalr) and discards wrong-path instructions.

---
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/gnt/rvalid, instruction FIFO, redirect.
// Optional FETCH_BYPASS_EN forwards rdata to decode when the FIFO is empty.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        resolve_valid,
    input  logic [1:0]  npc_op,
    input  logic [31:0] br_pc,
    input  logic [31:0] imm,
    input  logic [31:0] alu_c,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        misalign_err
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]   fpc;
    logic [31:0]   req_pc;
    logic          outstanding;
    logic          drop;
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic        redirect;
    logic [31:0] target;
    logic        grant;
    logic        resp;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_empty;

    assign redirect   = resolve_valid && (npc_op != 2'b00);
    assign target     = (npc_op == 2'b11) ? (alu_c & ~32'h1) : (br_pc + imm);
    assign fifo_empty = (count == '0);

    // Only one request in flight, and never more than the FIFO can absorb.
    assign imem_req  = !rst && pc_en && !outstanding && !redirect &&
                       ((count + CW'(outstanding)) < CW'(FIFO_DEPTH));
    assign imem_addr = fpc;
    assign grant     = imem_req && imem_gnt;

    assign resp   = imem_rvalid && outstanding;
    assign accept = resp && !drop && !redirect;
    assign pop    = !fifo_empty && inst_ready && !redirect;

`ifdef FETCH_BYPASS_EN
    logic byp;
    assign byp        = fifo_empty && accept;
    assign inst_valid = !fifo_empty || byp;
    assign inst       = fifo_empty ? imem_rdata : fifo_inst[rd_ptr];
    assign inst_pc    = fifo_empty ? req_pc : fifo_pc[rd_ptr];
    assign push       = accept && !(byp && inst_ready);
`else
    assign inst_valid = !fifo_empty;
    assign inst       = fifo_inst[rd_ptr];
    assign inst_pc    = fifo_pc[rd_ptr];
    assign push       = accept;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc          <= RESET_PC;
            req_pc       <= RESET_PC;
            outstanding  <= 1'b0;
            drop         <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            misalign_err <= 1'b0;
        end else if (redirect) begin
            fpc         <= {target[31:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            // A response landing now is consumed here, so no drop is owed.
            outstanding <= outstanding && !imem_rvalid;
            drop        <= outstanding && !imem_rvalid;
            if (target[1]) begin
                misalign_err <= 1'b1;
            end
        end else begin
            if (resp) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end
            if (grant) begin
                outstanding <= 1'b1;
                req_pc      <= fpc;
                fpc         <= fpc + 32'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based model.
module tb_fetch_unit;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        resolve_valid;
    logic [1:0]  npc_op;
    logic [31:0] br_pc;
    logic [31:0] imm;
    logic [31:0] alu_c;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misalign_err;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pc_en(pc_en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .resolve_valid(resolve_valid), .npc_op(npc_op), .br_pc(br_pc),
        .imm(imm), .alu_c(alu_c), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .misalign_err(misalign_err)
    );

    int npass = 0;
    int ntotal = 0;

    // model state
    logic [31:0] m_fpc, m_req_pc;
    logic        m_out, m_drop, m_mis;
    logic [63:0] m_q[$];

    // memory environment
    logic        env_pend;
    int          env_dly;
    logic [31:0] env_addr;
    int          dly_set;
    bit          rand_mode;

    // per-cycle observations
    logic        last_req, last_grant, last_valid, last_pop;
    logic [31:0] last_addr, last_pc, last_inst;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        ntotal++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        m_fpc = RPC; m_req_pc = RPC;
        m_out = 1'b0; m_drop = 1'b0; m_mis = 1'b0;
        m_q.delete();
    endtask

    task automatic cycle();
        logic        exp_req, redir, resp, byp, exp_valid, grant, pop;
        logic [31:0] exp_inst, exp_pc, tgt;
        if (rand_mode) begin
            pc_en         = ($urandom_range(0, 9) != 0);
            inst_ready    = ($urandom_range(0, 3) != 0);
            imem_gnt      = ($urandom_range(0, 2) != 0);
            resolve_valid = ($urandom_range(0, 11) == 0);
            npc_op        = 2'($urandom_range(0, 3));
            br_pc         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                                                        : ($urandom & 32'h0000_FFFC);
            imm           = 32'($urandom_range(0, 63)) * 4 - 32'd128;
            if ($urandom_range(0, 15) == 0) imm = imm + 32'd2;
            alu_c         = $urandom;
        end
        if (env_pend && env_dly == 0) begin
            imem_rvalid = 1'b1; imem_rdata = mem_word(env_addr);
        end else if (!env_pend && rand_mode && $urandom_range(0, 11) == 0) begin
            imem_rvalid = 1'b1; imem_rdata = $urandom;
        end else begin
            imem_rvalid = 1'b0; imem_rdata = $urandom;
        end
        @(negedge clk);
        redir   = resolve_valid && (npc_op != 2'b00);
        exp_req = !rst && pc_en && !m_out && (m_q.size() < DEPTH) && !redir;
        resp    = !rst && imem_rvalid && m_out;
        byp     = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = (m_q.size() == 0) && resp && !m_drop && !redir;
`endif
        exp_valid = (m_q.size() > 0) || byp;
        if (m_q.size() > 0) {exp_inst, exp_pc} = m_q[0];
        else {exp_inst, exp_pc} = {imem_rdata, m_req_pc};
        chk("imem_req", imem_req, exp_req);
        chk("imem_addr", imem_addr, m_fpc);
        chk("inst_valid", inst_valid, exp_valid);
        chk("misalign_err", misalign_err, m_mis);
        if (exp_valid) begin
            chk("inst", inst, exp_inst);
            chk("inst_pc", inst_pc, exp_pc);
        end
        last_req   = imem_req;
        last_addr  = imem_addr;
        last_grant = imem_req && imem_gnt;
        last_valid = inst_valid;
        last_pop   = inst_valid && inst_ready;
        last_pc    = inst_pc;
        last_inst  = inst;
        if (!rst) begin
            grant = exp_req && imem_gnt;
            if (redir) begin
                tgt = (npc_op == 2'b11) ? (alu_c & ~32'h1) : (br_pc + imm);
                m_fpc = tgt & ~32'h3;
                if (tgt[1]) m_mis = 1'b1;
                m_q.delete();
                m_drop = m_out && !resp;
                m_out  = m_out && !resp;
            end else begin
                pop = exp_valid && inst_ready;
                if (pop && m_q.size() > 0) void'(m_q.pop_front());
                if (resp) begin
                    if (!m_drop && !(byp && inst_ready))
                        m_q.push_back({imem_rdata, m_req_pc});
                    m_out = 1'b0; m_drop = 1'b0;
                end
                if (grant) begin
                    m_out = 1'b1; m_req_pc = m_fpc; m_fpc = m_fpc + 32'd4;
                end
            end
        end
        if (env_pend && env_dly == 0) env_pend = 1'b0;
        else if (env_pend) env_dly--;
        if (imem_req && imem_gnt) begin
            env_pend = 1'b1;
            env_addr = imem_addr;
            env_dly  = rand_mode ? int'($urandom_range(0, 2)) : dly_set;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_mis", misalign_err, 0);
        chk("rst_addr", imem_addr, RPC);
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic resolve(input logic [1:0] op, input logic [31:0] b,
                           input logic [31:0] i, input logic [31:0] a);
        resolve_valid = 1'b1; npc_op = op; br_pc = b; imm = i; alu_c = a;
        cycle();
        resolve_valid = 1'b0; npc_op = 2'b00;
    endtask

    logic [31:0] ga[$];
    logic [31:0] pops[$];
    int          first_valid;
    logic [31:0] fv_pc, fv_inst, fg_addr;
    int          ngrant;
    bit          found, saw8, got_g, got_v;

    initial begin
        rst = 1'b1; pc_en = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; resolve_valid = 1'b0; npc_op = 2'b00;
        br_pc = '0; imm = '0; alu_c = '0; inst_ready = 1'b0;
        env_pend = 1'b0; env_dly = 0; env_addr = '0; dly_set = 0;
        rand_mode = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // basic streaming
        pc_en = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1; dly_set = 0;
        hard_reset();
        first_valid = -1; fv_pc = 32'hDEAD; fv_inst = 32'hDEAD;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (last_grant) ga.push_back(last_addr);
            if (last_valid && first_valid < 0) begin
                first_valid = i; fv_pc = last_pc; fv_inst = last_inst;
            end
        end
        chk("t1_addr0", ga.size() > 0 ? ga[0] : 32'hDEAD, 32'h0);
        chk("t1_addr1", ga.size() > 1 ? ga[1] : 32'hDEAD, 32'h4);
        chk("t1_addr2", ga.size() > 2 ? ga[2] : 32'hDEAD, 32'h8);
`ifdef FETCH_BYPASS_EN
        chk("t1_latency", first_valid, 1);
`else
        chk("t1_latency", first_valid, 2);
`endif
        chk("t1_pc", fv_pc, 32'h0);
        chk("t1_inst", fv_inst, mem_word(32'h0));

        // backpressure fills the FIFO
        inst_ready = 1'b0;
        hard_reset();
        ngrant = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_grant) ngrant++;
        end
        chk("t2_ngrant", ngrant, 2);
        chk("t2_req_idle", last_req, 0);
        chk("t2_head_pc", last_pc, 32'h0);
        inst_ready = 1'b1;
        pops.delete(); got_g = 0; fg_addr = 32'hDEAD;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_pop) pops.push_back(last_pc);
            if (last_grant && !got_g) begin got_g = 1; fg_addr = last_addr; end
        end
        chk("t2_pop0", pops.size() > 0 ? pops[0] : 32'hDEAD, 32'h0);
        chk("t2_pop1", pops.size() > 1 ? pops[1] : 32'hDEAD, 32'h4);
        chk("t2_resume", fg_addr, 32'h8);

        // branch while fetch of 0x8 is in flight
        dly_set = 2;
        hard_reset();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (last_grant && last_addr == 32'h8) found = 1;
        end
        chk("t3_found8", found, 1);
        resolve(2'b01, 32'h4, 32'h20, 32'h0);
        got_g = 0; got_v = 0; saw8 = 0; fg_addr = 32'hDEAD; fv_pc = 32'hDEAD;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (last_grant && !got_g) begin got_g = 1; fg_addr = last_addr; end
            if (last_valid && !got_v) begin got_v = 1; fv_pc = last_pc; end
            if (last_valid && last_pc == 32'h8) saw8 = 1;
        end
        chk("t3_req", fg_addr, 32'h24);
        chk("t3_pc", fv_pc, 32'h24);
        chk("t3_no8", saw8, 0);

        // jalr clears bit0; jal to a bit1 target is flagged
        dly_set = 0;
        resolve(2'b11, 32'h0, 32'h0, 32'h1001);
        got_g = 0; fg_addr = 32'hDEAD;
        for (int i = 0; i < 20 && !got_g; i++) begin
            cycle();
            if (last_grant) begin got_g = 1; fg_addr = last_addr; end
        end
        chk("t4_jalr", fg_addr, 32'h1000);
        chk("t4_mis0", misalign_err, 0);
        resolve(2'b10, 32'h0, 32'h6, 32'h0);
        got_g = 0; fg_addr = 32'hDEAD;
        for (int i = 0; i < 20 && !got_g; i++) begin
            cycle();
            if (last_grant) begin got_g = 1; fg_addr = last_addr; end
        end
        chk("t4_jal", fg_addr, 32'h4);
        chk("t4_mis1", misalign_err, 1);
        for (int i = 0; i < 5; i++) cycle();
        chk("t4_sticky", misalign_err, 1);

        // reset with a request outstanding
        dly_set = 2;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (last_grant) found = 1;
        end
        chk("t5_grant", found, 1);
        hard_reset();
        dly_set = 0;
        got_g = 0; got_v = 0; fg_addr = 32'hDEAD; fv_pc = 32'hDEAD;
        fv_inst = 32'hDEAD;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (last_grant && !got_g) begin got_g = 1; fg_addr = last_addr; end
            if (last_valid && !got_v) begin
                got_v = 1; fv_pc = last_pc; fv_inst = last_inst;
            end
        end
        chk("t5_req", fg_addr, RPC);
        chk("t5_pc", fv_pc, RPC);
        chk("t5_inst", fv_inst, mem_word(RPC));

        // randomized traffic
        rand_mode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) hard_reset();
            else cycle();
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
